// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for the execute-stage op units: decodes one ARM
// data-processing word, fetches Rn/Rm, pulses en_inst, writes back Rd and owns C/Z/N.
module alu_issue_ctrl #(
    parameter logic [4:0] SUB_CODE      = 5'b00010,
    parameter logic [4:0] SBC_CODE      = 5'b00110,
    parameter int         SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [3:0]  rf_ra_addr,
    output logic [3:0]  rf_rb_addr,
    input  logic [31:0] rf_ra_data,
    input  logic [31:0] rf_rb_data,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        alu_en_inst,
    output logic        alu_imm,
    output logic [4:0]  alu_instruction,
    output logic        alu_s,
    output logic [31:0] alu_rn,
    output logic [11:0] alu_imm_operand,
    output logic [4:0]  alu_imm_shift,
    output logic [1:0]  alu_stype,
    output logic [31:0] alu_rm,
    output logic        alu_carry_in,
    output logic        alu_zero_in,
    output logic        alu_neg_in,
    input  logic [31:0] alu_rd,
    input  logic        alu_carry_out,
    input  logic        alu_zero_out,
    input  logic        alu_neg_out,
    output logic        flag_c,
    output logic        flag_z,
    output logic        flag_n,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {IDLE, RDREG, OPND, EXEC, WB, SKIP, ERR} state_t;

    state_t      state_q, state_d;
    logic        live_q;
    logic [31:0] instr_q, instr_d;
    logic [3:0]  ra_q, ra_d, rb_q, rb_d;
    logic [31:0] rn_q, rn_d, rm_q, rm_d, res_q, res_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  cznres_q, cznres_d;   // {C,Z,N} captured from the op unit
    logic [2:0]  flags_q, flags_d;     // {C,Z,N} architectural
    logic        legal, cond_ok;

    always_comb begin
        legal = (in_instr[27:26] == 2'b00)
             && (in_instr[24:21] == 4'b0010 || in_instr[24:21] == 4'b0110)
             && (in_instr[25] || !in_instr[4]);
        cond_ok = 1'b0;
        case (in_instr[31:28])
            4'b0000: cond_ok = flags_q[1];
            4'b0001: cond_ok = !flags_q[1];
            4'b0010: cond_ok = flags_q[2];
            4'b0011: cond_ok = !flags_q[2];
            4'b0100: cond_ok = flags_q[0];
            4'b0101: cond_ok = !flags_q[0];
            4'b1110: cond_ok = 1'b1;
            default: legal   = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rn_d     = rn_q;
        rm_d     = rm_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        cznres_d = cznres_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: if (in_valid && in_ready) begin
                instr_d = in_instr;
                if (!legal)
                    state_d = ERR;
                else if (!cond_ok)
                    state_d = SKIP;
                else begin
                    state_d = RDREG;
                    ra_d    = in_instr[19:16];
                    rb_d    = in_instr[3:0];
                end
            end
            RDREG: state_d = OPND;
            OPND: begin
                rn_d    = rf_ra_data;
                rm_d    = rf_rb_data;
                cnt_d   = '0;
                state_d = EXEC;
            end
            EXEC: begin
                if (cnt_q == 3'(SETTLE_CYCLES - 1)) begin
                    res_d    = alu_rd;
                    cznres_d = {alu_carry_out, alu_zero_out, alu_neg_out};
                    state_d  = WB;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WB: begin
                if (instr_q[20])
                    flags_d = cznres_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            live_q   <= 1'b0;
            instr_q  <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            cznres_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            live_q   <= 1'b1;
            instr_q  <= instr_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            cznres_q <= cznres_d;
            flags_q  <= flags_d;
        end
    end

    // live_q keeps in_ready low while reset is held even though state is IDLE
    assign in_ready        = live_q && (state_q == IDLE);
    assign rf_ra_addr      = ra_q;
    assign rf_rb_addr      = rb_q;
    assign rf_we           = (state_q == WB);
    assign rf_waddr        = instr_q[15:12];
    assign rf_wdata        = res_q;
    assign alu_en_inst     = (state_q == EXEC);
    assign alu_imm         = instr_q[25];
    assign alu_instruction = (instr_q[24:21] == 4'b0010) ? SUB_CODE : SBC_CODE;
    assign alu_s           = instr_q[20];
    assign alu_rn          = rn_q;
    assign alu_rm          = rm_q;
    assign alu_imm_operand = instr_q[11:0];
    assign alu_imm_shift   = instr_q[11:7];
    assign alu_stype       = instr_q[6:5];
    assign alu_carry_in    = flags_q[2];
    assign alu_zero_in     = flags_q[1];
    assign alu_neg_in      = flags_q[0];
    assign flag_c          = flags_q[2];
    assign flag_z          = flags_q[1];
    assign flag_n          = flags_q[0];
    assign done            = (state_q == WB) || (state_q == SKIP);
    assign illegal         = (state_q == ERR);

endmodule
